mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates the core's instruction-fetch port and data-access port onto one shared single-port memory bus with request/grant/response handshakes. Sits between the core and the RAM/peripheral fabric, so fetch and load/store can share one memory. Keeps one transaction outstanding, bounds fetch starvation, and converts a missing memory response into an error after a timeout.

## Interface
- TIMEOUT, 16: maximum WAIT cycles before a synthesized error response; valid range ≥2.
- MAX_WAIT, 4: lost arbitrations after which a pending fetch is forced to win; valid range ≥1.
- Reset is rst, synchronous, active-high. Clock is clk.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req_i  in  1  fetch request
- if_addr_i  in  32  fetch address; word read, all byte enables set
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch response valid; one cycle
- if_rdata_o  out  32  fetch read data
- if_err_o  out  1  fetch bus error or timeout
- d_req_i  in  1  data request
- d_we_i  in  1  1 = store, 0 = load
- d_be_i  in  4  byte enables
- d_addr_i  in  32  data address
- d_wdata_i  in  32  store data
- d_gnt_o, d_rvalid_o, d_err_o  out  1 each  same meaning as the fetch signals, for the data port
- d_rdata_o  out  32  load data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write
- mem_be_o  out  4  bus byte enables
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_gnt_i  in  1  bus accepted the request
- mem_rvalid_i  in  1  bus response valid
- mem_rdata_i  in  32  bus read data
- mem_err_i  in  1  bus error; qualified by mem_rvalid_i
- busy_o  out  1  state is not IDLE

## Operation
- **FSM states:** IDLE, ISSUE, WAIT.
- **IDLE:**
  - If any request is present, pick a winner.
  - Latch the owner and request fields: addr, we, be, wdata. For a fetch, latch we = 0 and be = 4'hF.
  - Assert the winner's gnt_o in the same cycle (combinational), then go to ISSUE.
  - The requester may drop or change its inputs after the grant cycle.
- **Priority:**
  - Data beats fetch by default.
  - starve_cnt counts IDLE cycles in which if_req_i = 1 and data won.
  - When starve_cnt == MAX_WAIT, fetch wins. starve_cnt clears whenever fetch is granted.
  - starve_cnt saturates at MAX_WAIT.
- **ISSUE:**
  - mem_req_o = 1, driven from the latched fields only.
  - Go to WAIT on mem_gnt_i. Otherwise hold the request, stable, indefinitely.
- **WAIT:**
  - mem_req_o = 0. to_cnt increments each cycle.
  - On mem_rvalid_i, the owner's rvalid_o = 1 in the same cycle, with rdata_o = mem_rdata_i and err_o = mem_err_i. Go to IDLE.
  - If to_cnt == TIMEOUT-1 without mem_rvalid_i, the owner gets rvalid_o = 1, err_o = 1, rdata_o = 0. Go to IDLE.
  - to_cnt clears on entry to WAIT.
- **Response routing:**
  - The non-owner's rvalid_o and err_o stay 0.
  - rdata_o is 0 whenever its rvalid_o = 0.
- **Stray responses:** mem_rvalid_i outside WAIT is ignored. The bus contract forbids responses after TIMEOUT cycles.
- **Simultaneous requests in IDLE:** exactly one grant. The loser must keep req asserted and is served next.
- **Reset mid-transaction:** the transaction is abandoned and no rvalid_o is issued.

## Timing
- **Reset values:** all outputs 0; state IDLE; starve_cnt = 0; to_cnt = 0.
- **Minimum transaction:**
  - cycle 0: gnt_o.
  - cycle 1: mem_req_o, with mem_gnt_i.
  - cycle 2: earliest mem_rvalid_i, giving rvalid_o.
  - cycle 3: IDLE, can grant again.
  - Peak throughput is one transaction per 3 cycles.
- **Combinational paths:** mem_rvalid_i/mem_rdata_i/mem_err_i to rvalid_o/rdata_o/err_o, and req_i to gnt_o.
- **Registered outputs:** mem_* outputs are driven only from registers.
- **Timeout:** error response on the TIMEOUT-th WAIT cycle.

## Structure
- **Package MemArb:**
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - owner_t enum {OWN_IF, OWN_D}.
  - Uses Common::uint32.
- **Sub-module arb_priority:** priority pick plus the starve_cnt register; outputs grant_if and grant_d.
- **Top level:** the FSM, latches, to_cnt and response routing stay in mem_port_arbiter.

## Test plan
- **Lone fetch:** if_req_i at 0x100, mem_gnt_i immediate, mem_rvalid_i on cycle 2 with rdata 0xDEADBEEF -> if_gnt_o on cycle 0; mem_addr_o = 0x100, mem_be_o = 4'hF, mem_we_o = 0; if_rvalid_o on cycle 2 with 0xDEADBEEF; d_rvalid_o stays 0.
- **Simultaneous requests:** if_req_i and d_req_i (store 0x55AA to 0x200, be = 4'h3) -> d_gnt_o first with mem_wdata_o = 0x55AA, mem_be_o = 4'h3; fetch granted in the IDLE cycle after the store response.
- **Starvation bound:** MAX_WAIT = 4, d_req_i and if_req_i held continuously -> four data grants, then one fetch grant, then data again.
- **Bus backpressure:** mem_gnt_i low for 5 cycles -> mem_req_o and mem_addr_o held stable for 6 cycles; transaction completes normally.
- **Timeout:** TIMEOUT = 16, no mem_rvalid_i -> owner rvalid_o = 1, err_o = 1, rdata_o = 0 on the 16th WAIT cycle; a later stray mem_rvalid_i produces no output.
- **Reset mid-transaction:** rst asserted in WAIT -> next cycle state IDLE, all outputs 0, no rvalid_o; a fresh request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter: FSM state, port owner and
// the latched bus request fields.
package mem_port_arbiter_pkg;

  typedef logic [31:0] uint32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} arb_state_t;

  typedef enum logic {OWN_IF, OWN_D} owner_t;

  typedef struct packed {
    logic       we;
    logic [3:0] be;
    uint32      addr;
    uint32      wdata;
  } req_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_port_arbiter_priority.sv
// Data-over-fetch priority pick with a saturating starvation counter; grants are
// combinational from the requests, so a losing requester just keeps asserting.
module mem_port_arbiter_priority #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pick,
  input  logic if_req,
  input  logic d_req,
  output logic grant_if,
  output logic grant_d
);

  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          starved;

  assign starved  = (starve_cnt == SW'(MAX_WAIT));
  assign grant_if = pick & if_req & (~d_req | starved);
  assign grant_d  = pick & d_req & ~grant_if;

  // Counts only arbitrations that fetch actually lost; saturates so a forced win is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && !starved) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports, one transaction outstanding;
// min 3 cycles per transaction, ISSUE holds indefinitely on mem_gnt_i low, WAIT times out.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  output logic        if_err_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [3:0]  d_be_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);

  localparam int TW = $clog2(TIMEOUT);

  arb_state_t    state;
  owner_t        owner;
  req_t          req_q;
  logic          mem_req_q;
  logic [TW-1:0] to_cnt;

  logic  pick, grant_if, grant_d;
  logic  mem_resp, timed_out, resp_vld, resp_err;
  uint32 resp_dat;

  assign pick = (state == ARB_IDLE) && !rst;

  mem_port_arbiter_priority #(.MAX_WAIT(MAX_WAIT)) u_priority (
    .clk      (clk),
    .rst      (rst),
    .pick     (pick),
    .if_req   (if_req_i),
    .d_req    (d_req_i),
    .grant_if (grant_if),
    .grant_d  (grant_d)
  );

  assign if_gnt_o = grant_if;
  assign d_gnt_o  = grant_d;

  // Responses are only honoured in WAIT; a reset cycle suppresses them so an abandoned
  // transaction never reports back.
  assign mem_resp  = (state == ARB_WAIT) && !rst && mem_rvalid_i;
  assign timed_out = (state == ARB_WAIT) && !rst && !mem_rvalid_i && (to_cnt == TW'(TIMEOUT - 1));
  assign resp_vld  = mem_resp | timed_out;
  assign resp_err  = mem_resp ? mem_err_i : timed_out;
  assign resp_dat  = mem_resp ? mem_rdata_i : '0;

  assign if_rvalid_o = resp_vld && (owner == OWN_IF);
  assign if_err_o    = resp_err && (owner == OWN_IF);
  assign if_rdata_o  = (owner == OWN_IF) ? resp_dat : '0;
  assign d_rvalid_o  = resp_vld && (owner == OWN_D);
  assign d_err_o     = resp_err && (owner == OWN_D);
  assign d_rdata_o   = (owner == OWN_D) ? resp_dat : '0;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = req_q.we;
  assign mem_be_o    = req_q.be;
  assign mem_addr_o  = req_q.addr;
  assign mem_wdata_o = req_q.wdata;
  assign busy_o      = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      req_q     <= '0;
      mem_req_q <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant_if) begin
            owner     <= OWN_IF;
            req_q     <= '{we: 1'b0, be: BE_WORD, addr: if_addr_i, wdata: '0};
            mem_req_q <= 1'b1;
            state     <= ARB_ISSUE;
          end else if (grant_d) begin
            owner     <= OWN_D;
            req_q     <= '{we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};
            mem_req_q <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_gnt_i) begin
            mem_req_q <= 1'b0;
            to_cnt    <= '0;
            state     <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          to_cnt <= to_cnt + TW'(1);
          if (resp_vld) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule
